// File: rtl/shift_pin_sout_if.sv
// Core-side load port of the serial transmitter: a WIDTH-bit word handed over
// with a valid/ready handshake. Index 0 of pdata is the first bit sent.
interface shift_pin_sout_if #(
    parameter int WIDTH = 8
);
    logic [0:WIDTH-1] pdata;
    logic             pdata_valid;
    logic             pdata_ready;

    modport master (
        output pdata,
        output pdata_valid,
        input  pdata_ready
    );

    modport slave (
        input  pdata,
        input  pdata_valid,
        output pdata_ready
    );
endinterface

// File: rtl/shift_pin_sout.sv
// Parallel-in, serial-out transmitter. The core loads a holding register; the
// host latches it into a shifter with le and clocks it out on dout with sclk.
module shift_pin_sout #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_pin_sout_if.slave   core,
    input  logic              sclk,
    input  logic              cs,
    input  logic              le,
    output logic              dout,
    output logic              busy,
    output logic              taken,
    output logic              underrun,
    output logic              done,
    output logic              abort
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Host pins, one synchroniser lane each: 0 = sclk, 1 = cs, 2 = le.
    localparam int LANE_SCLK = 0;
    localparam int LANE_CS   = 1;
    localparam int LANE_LE   = 2;
    localparam int LANES     = 3;

    logic [LANES-1:0] host_in;
    logic [LANES-1:0] level_s;
    logic [LANES-1:0] rise_s;

    assign host_in[LANE_SCLK] = sclk;
    assign host_in[LANE_CS]   = cs;
    assign host_in[LANE_LE]   = le;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   hist_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= '0;
                    hist_reg  <= 1'b0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], host_in[gi]};
                    hist_reg  <= chain_reg[SYNC_STAGES-1];
                end
            end

            assign level_s[gi] = chain_reg[SYNC_STAGES-1];
            assign rise_s[gi]  = chain_reg[SYNC_STAGES-1] & ~hist_reg;
        end
    endgenerate

    logic [0:WIDTH-1] hold_reg,      hold_next;
    logic             hold_full_reg, hold_full_next;
    logic [0:WIDTH-1] sh_reg,        sh_next;
    logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [0:0]       state_reg,     state_next;
    logic             taken_reg,     taken_next;
    logic             underrun_reg,  underrun_next;
    logic             done_reg,      done_next;
    logic             abort_reg,     abort_next;

    logic cs_s;
    logic le_s;
    logic accept;
    logic snap_ev;
    logic shift_ev;
    logic drop_ev;

    assign cs_s = level_s[LANE_CS];
    assign le_s = level_s[LANE_LE];

    assign accept   = core.pdata_valid && !hold_full_reg;
    assign snap_ev  = rise_s[LANE_LE] && cs_s;
    assign shift_ev = rise_s[LANE_SCLK] && cs_s && !le_s && (state_reg == ST_SHIFT);
    assign drop_ev  = !cs_s;

    assign bit_cnt_inc = bit_cnt_reg + CNT_W'(1);

    always_comb begin
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        sh_next        = sh_reg;
        bit_cnt_next   = bit_cnt_reg;
        state_next     = state_reg;
        taken_next     = 1'b0;
        underrun_next  = 1'b0;
        done_next      = 1'b0;
        abort_next     = 1'b0;

        // drop outranks snap, snap outranks shift; a shift coinciding with a
        // snap is swallowed so the new word always starts at bit 0.
        if ((state_reg == ST_SHIFT) && drop_ev) begin
            state_next   = ST_IDLE;
            sh_next      = '0;
            bit_cnt_next = '0;
            abort_next   = 1'b1;
        end else if (snap_ev) begin
            if (hold_full_reg) begin
                sh_next        = hold_reg;
                hold_full_next = 1'b0;
                taken_next     = 1'b1;
            end else begin
                sh_next       = '0;
                underrun_next = 1'b1;
            end
            bit_cnt_next = '0;
            state_next   = ST_SHIFT;
        end else if (shift_ev) begin
            if (bit_cnt_inc == CNT_W'(WIDTH)) begin
                state_next   = ST_IDLE;
                sh_next      = '0;
                bit_cnt_next = '0;
                done_next    = 1'b1;
            end else begin
                sh_next      = {sh_reg[1:WIDTH-1], 1'b0};
                bit_cnt_next = bit_cnt_inc;
            end
        end

        // Accept is only possible while empty, so it never collides with the
        // snapshot clearing hold_full; a same-cycle word simply lands afterwards.
        if (accept) begin
            hold_next      = core.pdata;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            sh_reg        <= '0;
            bit_cnt_reg   <= '0;
            state_reg     <= ST_IDLE;
            taken_reg     <= 1'b0;
            underrun_reg  <= 1'b0;
            done_reg      <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            sh_reg        <= sh_next;
            bit_cnt_reg   <= bit_cnt_next;
            state_reg     <= state_next;
            taken_reg     <= taken_next;
            underrun_reg  <= underrun_next;
            done_reg      <= done_next;
            abort_reg     <= abort_next;
        end
    end

    // sh_reg is cleared on every return to IDLE, gating keeps dout low anyway.
    assign dout             = (state_reg == ST_SHIFT) && sh_reg[0];
    assign busy             = (state_reg == ST_SHIFT);
    assign taken            = taken_reg;
    assign underrun         = underrun_reg;
    assign done             = done_reg;
    assign abort            = abort_reg;
    assign core.pdata_ready = !hold_full_reg;

endmodule
